// File: rtl/ixc_sample_hist.sv
// ixc_sample_hist: samples a WIDTH-bit vector each fclk under a selectable
// mode and keeps a DEPTH-entry history FIFO drained by a valid/enable reader.
// Ports:
//   fclk, rst              clock, async active-high reset
//   v, mode, trig, clr     sample input, mode select, strobe, flush
//   ov, chg                current sample, changed-on-last-update flag
//   rd_en                  pop request
//   rd_data, rd_valid      popped entry and its one-cycle valid
//   count, ovf             occupancy, sticky overflow
module ixc_sample_hist #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v,
  input  logic [1:0]       mode,
  input  logic             trig,
  input  logic             clr,
  output logic [WIDTH-1:0] ov,
  output logic             chg,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    HOLD   = 2'd1,
    TRIG   = 2'd2,
    CHANGE = 2'd3
  } mode_e;

  logic [WIDTH-1:0] ov_q, ov_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic diff, upd, push, pop, full, acc, wr_en;

  assign diff = (v != ov_q);
  assign full = (count_q == CW'(DEPTH));
  assign pop  = rd_en && (count_q != '0);

  always_comb begin
    upd  = 1'b0;
    push = 1'b0;
    unique case (mode_e'(mode))
      TRACK:  upd = 1'b1;
      HOLD:   upd = 1'b0;
      TRIG: begin
        upd  = trig;
        push = trig;
      end
      CHANGE: begin
        upd  = diff;
        push = diff;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign acc   = push && (!full || pop);
  assign wr_en = acc && !clr;

  always_comb begin
    ov_d       = ov_q;
    chg_d      = upd && diff;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    count_d    = count_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (upd) ov_d = v;
    if (clr) begin
      count_d  = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PW'(1);
      end
      if (acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push && !acc) ovf_d = 1'b1;
      count_d = count_q + CW'(acc) - CW'(pop);
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      ov_q       <= '0;
      chg_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      ov_q       <= ov_d;
      chg_q      <= chg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge fclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= v;
  end

  assign ov       = ov_q;
  assign chg      = chg_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ixc_sample_hist.sv
// tb_ixc_sample_hist: directed + random stimulus for ixc_sample_hist,
// compared every cycle against a queue-based reference model.
module tb_ixc_sample_hist;

  logic        fclk;
  logic        rst;
  logic [31:0] v;
  logic [1:0]  mode;
  logic        trig;
  logic        clr;
  logic [31:0] ov;
  logic        chg;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        ovf;

  ixc_sample_hist #(.WIDTH(32), .DEPTH(8)) dut (
    .fclk     (fclk),
    .rst      (rst),
    .v        (v),
    .mode     (mode),
    .trig     (trig),
    .clr      (clr),
    .ov       (ov),
    .chg      (chg),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .ovf      (ovf)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_ov, m_rdd;
  logic        m_chg, m_rdv, m_ovf;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ov = '0; m_chg = 0; m_rdd = '0; m_rdv = 0; m_ovf = 0;
    q.delete();
  endtask

  // One edge of the reference: pop frees a slot before the push is sized.
  task automatic m_step();
    bit d, u, p;
    d = (v != m_ov);
    case (mode)
      2'd0: begin u = 1; p = 0; end
      2'd1: begin u = 0; p = 0; end
      2'd2: begin u = trig; p = trig; end
      default: begin u = d; p = d; end
    endcase
    if (clr) begin
      q.delete(); m_ovf = 0; m_rdv = 0;
    end else begin
      m_rdv = rd_en && q.size() > 0;
      if (m_rdv) m_rdd = q.pop_front();
      if (p) begin
        if (q.size() < 8) q.push_back(v);
        else m_ovf = 1;
      end
    end
    m_chg = u && d;
    if (u) m_ov = v;
  endtask

  task automatic chk_all();
    chk("ov", ov, m_ov);
    chk("chg", 32'(chg), 32'(m_chg));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("rd_data", rd_data, m_rdd);
    chk("count", 32'(count), 32'(q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic cyc(input logic [1:0] md, input logic [31:0] vv,
                     input logic tg, input logic cl, input logic re);
    mode = md; v = vv; trig = tg; clr = cl; rd_en = re;
    @(posedge fclk);
    m_step();
    #1 chk_all();
  endtask

  logic [31:0] last;

  initial begin
    rst = 1; v = 32'hDEADBEEF; mode = 0; trig = 0; clr = 0; rd_en = 0;
    m_reset();
    repeat (2) @(posedge fclk);
    #1;
    chk("rst_ov", ov, 32'h0);
    chk_all();
    #3 rst = 0;

    // TRACK after reset
    cyc(0, 32'hDEADBEEF, 0, 0, 0);
    chk("track_ov", ov, 32'hDEADBEEF);
    chk("track_chg", 32'(chg), 32'd1);
    cyc(0, 32'hDEADBEEF, 0, 0, 0);
    chk("track_chg0", 32'(chg), 32'd0);

    // TRIG: strobes on 2 and 4
    for (int i = 1; i <= 4; i++) cyc(2, 32'(i), (i % 2) == 0, 0, 0);
    chk("trig_ov", ov, 32'd4);
    chk("trig_cnt", 32'(count), 32'd2);
    cyc(2, 4, 0, 0, 1);
    chk("trig_rd0", rd_data, 32'd2);
    cyc(2, 4, 0, 0, 1);
    chk("trig_rd1", rd_data, 32'd4);
    chk("trig_rdv", 32'(rd_valid), 32'd1);

    // CHANGE with overflow
    for (int i = 1; i <= 10; i++) cyc(3, 32'(i), 0, 0, 0);
    chk("ovf_cnt", 32'(count), 32'd8);
    chk("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 32'h55, 0, 0, 1);
      chk("ovf_pop", rd_data, 32'(i));
    end
    cyc(1, 10, 0, 1, 0);
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_ov", ov, 32'd10);

    // Full with simultaneous pop
    for (int i = 1; i <= 8; i++) cyc(2, 32'(i), 1, 0, 0);
    cyc(2, 9, 1, 0, 1);
    chk("fp_cnt", 32'(count), 32'd8);
    chk("fp_ovf", 32'(ovf), 32'd0);
    last = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 1);
      last = rd_data;
    end
    chk("fp_last", last, 32'd9);

    // HOLD and empty read
    cyc(1, 32'hAAAA, 0, 0, 0);
    cyc(1, 32'h5555, 0, 0, 1);
    chk("hold_ov", ov, 32'd9);
    chk("hold_chg", 32'(chg), 32'd0);
    chk("empty_rdv", 32'(rd_valid), 32'd0);
    chk("empty_cnt", 32'(count), 32'd0);

    // Async reset mid-stream
    for (int i = 0; i < 5; i++) cyc(2, 32'(100 + i), 1, 0, 0);
    chk("pre_rst_cnt", 32'(count), 32'd5);
    #3 rst = 1;
    #1;
    m_reset();
    chk("arst_ov", ov, 32'h0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk_all();
    #2 rst = 0;
    cyc(2, 32'hA5A5A5A5, 1, 0, 0);
    cyc(2, 0, 0, 0, 1);
    chk("arst_rd", rd_data, 32'hA5A5A5A5);
    chk("arst_rdv", 32'(rd_valid), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(2'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0,
          $urandom_range(0, 2) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ixc_sample_hist.md
# ixc_sample_hist

Parametrised successor to the fixed 32-bit sample-latch array: registers a WIDTH-bit vector every `fclk` under a selectable sampling mode and keeps a DEPTH-entry history FIFO of captured values that the host-side readout logic drains with a valid/enable handshake. Sits in the IXCOM template library between design probe points and the emulator upload path, replacing per-width sample arrays where triggered or change-only capture is needed.

## Interface
- WIDTH, 32, sampled vector width (≥1)
- DEPTH, 8, history FIFO entries (power of 2, ≥2)
- CW, $clog2(DEPTH+1), width of `count` (derived, not overridable)

- fclk  in  1  sampling clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- v  in  WIDTH  vector to sample
- mode  in  2  0 TRACK, 1 HOLD, 2 TRIG, 3 CHANGE
- trig  in  1  capture strobe (used in TRIG mode only)
- clr  in  1  synchronous flush of FIFO and `ovf`
- ov  out  WIDTH  current sampled value
- chg  out  1  registered: `ov` changed value on the last update
- rd_en  in  1  pop request from readout
- rd_data  out  WIDTH  popped entry
- rd_valid  out  1  `rd_data` valid, one-cycle pulse
- count  out  CW  FIFO occupancy, 0..DEPTH
- ovf  out  1  sticky: a push was dropped while full

## Operation
- Reset (async assert, sync-free deassert): `ov`=0, `chg`=0, `rd_data`=0, `rd_valid`=0, `count`=0, `ovf`=0, pointers 0. Reset mid-stream discards all FIFO contents.
- Update condition `upd`: TRACK → 1; HOLD → 0; TRIG → `trig`; CHANGE → (`v` != `ov`).
- On `upd`: `ov` <= `v`. `chg` <= `upd` && (`v` != `ov`); otherwise `chg` <= 0.
- Push condition `push`: TRIG → `trig`; CHANGE → (`v` != `ov`); TRACK/HOLD → 0. Pushed data is `v` (the value being loaded into `ov`).
- Pop condition `pop` = `rd_en` && (`count` != 0). `rd_en` on empty is ignored (no pulse, no error).
- Full handling: push accepted if `count` < DEPTH, or if `pop` in the same cycle (pop frees a slot first). Otherwise push dropped, `ovf` <= 1.
- `count` next = `count` + accepted push − pop; never exceeds DEPTH, never wraps below 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty derived from `count`, not pointer compare.
- `clr`: `count`, pointers, `ovf` <= 0; `rd_valid` <= 0; push and pop in that cycle discarded. `ov`/`chg` unaffected by `clr`.
- Mode changes take effect the same cycle; no pipeline drain. HOLD freezes `ov` but FIFO still drains.
- FIFO order strictly oldest-first.

## Timing
- `v` → `ov`: 1 cycle latency on `upd`.
- `chg` asserted the cycle `ov` shows the new value, for one cycle per update.
- `rd_en` at edge N (non-empty) → `rd_data`/`rd_valid` at N+1; `rd_valid` low otherwise; `rd_data` holds last popped value when `rd_valid` low.
- Back-to-back `rd_en` gives one entry per cycle.
- `count`, `ovf` registered, reflect the edge's push/pop.
- Push at edge N readable by `rd_en` at edge N+1 (no same-cycle bypass; empty-FIFO `rd_en` at N is ignored).

## Test plan
- Reset/TRACK: hold `rst`=1, drive `v`=32'hDEADBEEF → `ov`=0; release, next edge `ov`=32'hDEADBEEF, `chg`=1, `count`=0; repeat same `v` → `chg`=0.
- TRIG: mode=2, `v` ramps 1,2,3,4, `trig` only on 2 and 4 → `ov` ends at 4, `count`=2; `rd_en` two cycles → `rd_data` 2 then 4 with `rd_valid`=1 each.
- CHANGE + overflow (DEPTH=8): mode=3, `v` increments 1..10 each cycle, no reads → `count`=8, `ovf`=1, pops return 1..8; `clr` → `count`=0, `ovf`=0, `ov`=10 retained.
- Full with simultaneous pop: fill to 8, same cycle push value 9 and `rd_en` → `count` stays 8, `ovf`=0, last entry read is 9.
- HOLD + empty read: mode=1, `v` toggles → `ov` unchanged, `chg`=0; `rd_en` with `count`=0 → `rd_valid`=0, `count`=0.
- Async reset mid-operation: `count`=5, assert `rst` between edges → all outputs 0 immediately; after release first push lands at pointer 0 and reads back correctly.
